// File: rtl/uart_reply_tx.sv
// Reply formatter for the PIC UART link: turns a (kind, value) request into a
// framed ASCII reply ('$dd' / '#dd' / '?') and streams it over valid/ready.
module uart_reply_tx #(
  parameter bit         SEND_CRLF = 1'b1,
  parameter logic [7:0] FAIL_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  input  logic [7:0] req_value,
  output logic       to_uart_valid,
  output logic [7:0] to_uart_data,
  input  logic       to_uart_ready,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND_HDR,
    SEND_D1,
    SEND_D0,
    SEND_CR,
    SEND_LF
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] rem;
  logic [3:0] tens;
  logic       kind_q;
  logic       fail_q;
  logic       accept;
  logic       byte_taken;

  assign accept     = (state == IDLE) && req_valid;
  assign byte_taken = to_uart_valid && to_uart_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_kind[1] || (req_value > 8'd99)) begin
            next_state = SEND_HDR;
          end else begin
            next_state = CONV;
          end
        end
      end
      CONV: begin
        if (rem < 8'd10) begin
          next_state = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (to_uart_ready) begin
          if (!fail_q) begin
            next_state = SEND_D1;
          end else if (SEND_CRLF) begin
            next_state = SEND_CR;
          end else begin
            next_state = SEND_LF;
          end
        end
      end
      SEND_D1: begin
        if (to_uart_ready) begin
          next_state = SEND_D0;
        end
      end
      SEND_D0: begin
        if (to_uart_ready) begin
          if (SEND_CRLF) begin
            next_state = SEND_CR;
          end else begin
            next_state = SEND_LF;
          end
        end
      end
      SEND_CR: begin
        if (to_uart_ready) begin
          next_state = SEND_LF;
        end
      end
      SEND_LF: begin
        if (to_uart_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    to_uart_valid = 1'b0;
    to_uart_data  = 8'h00;
    case (state)
      IDLE: req_ready = 1'b1;
      SEND_HDR: begin
        to_uart_valid = 1'b1;
        if (fail_q) begin
          to_uart_data = FAIL_CHAR;
        end else if (kind_q) begin
          to_uart_data = 8'h23;
        end else begin
          to_uart_data = 8'h24;
        end
      end
      SEND_D1: begin
        to_uart_valid = 1'b1;
        to_uart_data  = 8'h30 + {4'h0, tens};
      end
      SEND_D0: begin
        to_uart_valid = 1'b1;
        to_uart_data  = 8'h30 + rem;
      end
      SEND_CR: begin
        to_uart_valid = 1'b1;
        to_uart_data  = 8'h0D;
      end
      SEND_LF: begin
        to_uart_valid = 1'b1;
        to_uart_data  = 8'h0A;
      end
      default: begin
        req_ready     = 1'b0;
        to_uart_valid = 1'b0;
      end
    endcase
  end

  // Decimal conversion by repeated subtraction; request fields are frozen at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= 8'd0;
      tens   <= 4'd0;
      kind_q <= 1'b0;
      fail_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == SEND_LF) && byte_taken;
      if (accept) begin
        rem    <= req_value;
        tens   <= 4'd0;
        kind_q <= req_kind[0];
        fail_q <= req_kind[1] || (req_value > 8'd99);
      end else if ((state == CONV) && (rem >= 8'd10)) begin
        rem  <= rem - 8'd10;
        tens <= tens + 4'd1;
      end
    end
  end

endmodule
